decode_execute_reg: RTL and testbench
=====================================

Name: decode_execute_reg

Overview:
- Decode→execute pipeline register. Captures decode-stage control and operands, and drives the execute stage: the condition-check/flag unit, ALU and forwarding muxes.
- Supports stall (hold), flush (bubble insertion), and multi-cycle occupancy of E for long-latency ops such as MUL. While a multi-cycle op occupies E, it raises BusyE so the hazard unit stalls F/D.
- Write-type controls are masked until the final occupancy cycle, so downstream stages never see duplicated writes.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 4, register-file address width
ALUC_W, 3, ALUControl width
MULT_LAT, 3, E-stage occupancy in cycles for MultiCycleD ops (legal 1..15; 1 = single-cycle)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (reset=0 clears all state)
StallE  in  1  hold register contents and counter
FlushE  in  1  load bubble; priority over StallE
ValidD  in  1  decode slot holds a real instruction
MultiCycleD  in  1  instruction requires MULT_LAT cycles in E
PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, NoWriteD  in  1 each  decode controls
FlagWriteD  in  2  flag-group write enables
CondD  in  4  condition field
ALUControlD  in  ALUC_W  ALU op
RD1D, RD2D, ExtImmD  in  DATA_W each  operands/immediate
RA1D, RA2D, WA3D  in  REG_AW each  source/dest register addresses
PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, NoWriteE  out  1 each  registered controls (write-type ones masked, see Behaviour)
FlagWriteE  out  2  registered, masked
CondE  out  4
ALUControlE  out  ALUC_W
RD1E, RD2E, ExtImmE  out  DATA_W each
RA1E, RA2E, WA3E  out  REG_AW each
ValidE  out  1  E slot holds a real instruction
BusyE  out  1  multi-cycle op still occupying E; hazard unit stalls F/D

Behaviour:
- Reset (reset=0, async): every output 0; FSM=IDLE; cnt=0.
- FSM states: IDLE (single-cycle flow) and HOLD (multi-cycle op resident). cnt is 4-bit.
- Update priority at posedge clk: FlushE > StallE > HOLD countdown > load.
- FlushE=1: all captured fields←0; ValidE←0; FSM←IDLE; cnt←0. Applies in any state, including mid-HOLD, which aborts the op.
- StallE=1 (no flush): all registers, FSM and cnt hold.
- HOLD with cnt>1: decrement cnt; payload held.
- HOLD with cnt==1: cnt←0; FSM←IDLE; payload held.
- Load (IDLE, no flush/stall): capture all D fields; ValidE←ValidD.
  - If ValidD & MultiCycleD & MULT_LAT>1: FSM←HOLD, cnt←MULT_LAT-1.
- BusyE = (FSM==HOLD). It is driven from registered state; there is no combinational path from D inputs.
- Masking: PCSrcE, RegWriteE, MemWriteE, BranchE, FlagWriteE = registered value & ~BusyE & ValidE. All other outputs are raw registered values.
- Latency: single-cycle op visible one cycle after load.
- Multi-cycle op occupies E for exactly MULT_LAT cycles (plus any stall cycles). Writes are unmasked only in the last of those cycles.
- The bubble must not look taken to the condition unit: all write-type controls are 0, which is sufficient regardless of CondE.
- MULT_LAT=1: MultiCycleD is ignored; FSM never leaves IDLE.

Optional Feature:
- Macro DE_PERF_CNT_EN.
- When defined, add 32-bit outputs BubbleCntE and BusyCntE:
  - BubbleCntE increments on each FlushE edge.
  - BusyCntE increments each cycle BusyE=1 and StallE=0.
  - Both wrap at 2^32 and clear on reset.
- When undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package de_pkg holds:
  - typedef struct packed for the control bundle (PCSrc, RegWrite, MemWrite, MemtoReg, Branch, ALUSrc, NoWrite, FlagWrite, Cond, ALUControl);
  - enum {IDLE, HOLD};
  - constant BUBBLE_CTRL = '0.
- One sub-module, occupancy_ctr, holds the FSM plus cnt and outputs BusyE.
- Data fields use the existing flopenr-style enable flops.

Test Plan:
- Reset: assert reset=0 mid-run with nonzero D inputs → all outputs 0, BusyE=0 immediately (asynchronous); after release, first load appears one cycle later.
- Single-cycle: RegWriteD=1, RD1D=32'h0000_00A5, WA3D=4'd3, ValidD=1 → next cycle RegWriteE=1, RD1E=32'hA5, WA3E=3, ValidE=1.
- Multi-cycle, MULT_LAT=3, MultiCycleD=1, RegWriteD=1:
  - cycles 1–2: BusyE=1, RegWriteE=0, WA3E stable;
  - cycle 3: BusyE=0, RegWriteE=1;
  - cycle 4: next D instruction loaded.
- Stall mid-HOLD: StallE=1 for 2 cycles during cnt=1 → BusyE stays 1 for 2 extra cycles, payload unchanged; total occupancy 5 cycles.
- Flush vs stall: FlushE=1 and StallE=1 together during HOLD → next cycle all controls 0, ValidE=0, BusyE=0, FSM IDLE.
- DE_PERF_CNT_EN: 3 flushes plus one MULT_LAT=3 op with no stalls → BubbleCntE=3, BusyCntE=2.

Source files
------------

// File: rtl/decode_execute_reg_pkg.sv
// Shared types for the decode->execute pipeline register: the control bundle,
// the occupancy FSM state encoding and the bubble constant.
package de_pkg;

  localparam int DE_ALUC_W = 3;

  typedef struct packed {
    logic                 PCSrc;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 MemtoReg;
    logic                 Branch;
    logic                 ALUSrc;
    logic                 NoWrite;
    logic [1:0]           FlagWrite;
    logic [3:0]           Cond;
    logic [DE_ALUC_W-1:0] ALUControl;
  } ctrl_t;

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} occ_state_e;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/decode_execute_reg_if.sv
// Decode-side inputs, execute-side outputs and the hazard-unit controls of the
// D->E register. slave = the register itself, master = whoever drives decode.
interface decode_execute_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int ALUC_W = 3
);
    logic              StallE, FlushE;
    logic              ValidD, MultiCycleD;
    logic              PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, NoWriteD;
    logic [1:0]        FlagWriteD;
    logic [3:0]        CondD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [DATA_W-1:0] RD1D, RD2D, ExtImmD;
    logic [REG_AW-1:0] RA1D, RA2D, WA3D;

    logic              PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, NoWriteE;
    logic [1:0]        FlagWriteE;
    logic [3:0]        CondE;
    logic [ALUC_W-1:0] ALUControlE;
    logic [DATA_W-1:0] RD1E, RD2E, ExtImmE;
    logic [REG_AW-1:0] RA1E, RA2E, WA3E;
    logic              ValidE, BusyE;

    modport slave (
        input  StallE, FlushE, ValidD, MultiCycleD,
               PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, NoWriteD,
               FlagWriteD, CondD, ALUControlD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
        output PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, NoWriteE,
               FlagWriteE, CondE, ALUControlE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
               ValidE, BusyE
    );

    modport master (
        output StallE, FlushE, ValidD, MultiCycleD,
               PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, NoWriteD,
               FlagWriteD, CondD, ALUControlD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
        input  PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, NoWriteE,
               FlagWriteE, CondE, ALUControlE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
               ValidE, BusyE
    );
endinterface

// File: rtl/decode_execute_reg_occupancy_ctr.sv
// E-stage occupancy tracker: IDLE/HOLD FSM with a 4-bit countdown; busy_o is
// purely registered state so the hazard unit sees no path from decode inputs.
module occupancy_ctr
    import de_pkg::*;
#(
    parameter int MULT_LAT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic stall_i,
    input  logic start_i,
    output logic busy_o
);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;
    localparam logic [3:0] LAT_M1  = 4'(MULT_LAT - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else if (!stall_i) begin
            if (state_q == ST_HOLD) begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            // The load cycle itself is the first occupancy cycle, hence MULT_LAT-1.
            end else if (start_i && (MULT_LAT > 1)) begin
                state_d = ST_HOLD;
                cnt_d   = LAT_M1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == ST_HOLD);
endmodule

// File: rtl/decode_execute_reg.sv
// Decode->execute pipeline register with stall, flush and multi-cycle occupancy.
// Optional macro DE_PERF_CNT_EN adds BubbleCntE/BusyCntE performance counters.
module decode_execute_reg
    import de_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int ALUC_W   = DE_ALUC_W,
    parameter int MULT_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    decode_execute_reg_if.slave bus
`ifdef DE_PERF_CNT_EN
    ,
    output logic [31:0] BubbleCntE,
    output logic [31:0] BusyCntE
`endif
);
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
    logic [REG_AW-1:0] ra1_q, ra2_q, wa3_q;
    logic              valid_q;
    logic              busy;
    logic              load;
    logic              wr_en;

    always_comb begin
        ctrl_d            = BUBBLE_CTRL;
        ctrl_d.PCSrc      = bus.PCSrcD;
        ctrl_d.RegWrite   = bus.RegWriteD;
        ctrl_d.MemWrite   = bus.MemWriteD;
        ctrl_d.MemtoReg   = bus.MemtoRegD;
        ctrl_d.Branch     = bus.BranchD;
        ctrl_d.ALUSrc     = bus.ALUSrcD;
        ctrl_d.NoWrite    = bus.NoWriteD;
        ctrl_d.FlagWrite  = bus.FlagWriteD;
        ctrl_d.Cond       = bus.CondD;
        ctrl_d.ALUControl = bus.ALUControlD;
    end

    // A resident multi-cycle op blocks new loads until its last occupancy cycle ends.
    assign load = !bus.FlushE && !bus.StallE && !busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= BUBBLE_CTRL;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            wa3_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.FlushE) begin
            ctrl_q  <= BUBBLE_CTRL;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            wa3_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            ctrl_q  <= ctrl_d;
            rd1_q   <= bus.RD1D;
            rd2_q   <= bus.RD2D;
            imm_q   <= bus.ExtImmD;
            ra1_q   <= bus.RA1D;
            ra2_q   <= bus.RA2D;
            wa3_q   <= bus.WA3D;
            valid_q <= bus.ValidD;
        end
    end

    occupancy_ctr #(.MULT_LAT(MULT_LAT)) u_occ (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (bus.FlushE),
        .stall_i (bus.StallE),
        .start_i (bus.ValidD && bus.MultiCycleD),
        .busy_o  (busy)
    );

    // Write-type controls only escape in the final occupancy cycle of a real instruction.
    assign wr_en          = valid_q && !busy;
    assign bus.PCSrcE     = ctrl_q.PCSrc    & wr_en;
    assign bus.RegWriteE  = ctrl_q.RegWrite & wr_en;
    assign bus.MemWriteE  = ctrl_q.MemWrite & wr_en;
    assign bus.BranchE    = ctrl_q.Branch   & wr_en;
    assign bus.FlagWriteE = ctrl_q.FlagWrite & {2{wr_en}};
    assign bus.MemtoRegE  = ctrl_q.MemtoReg;
    assign bus.ALUSrcE    = ctrl_q.ALUSrc;
    assign bus.NoWriteE   = ctrl_q.NoWrite;
    assign bus.CondE      = ctrl_q.Cond;
    assign bus.ALUControlE = ctrl_q.ALUControl;
    assign bus.RD1E       = rd1_q;
    assign bus.RD2E       = rd2_q;
    assign bus.ExtImmE    = imm_q;
    assign bus.RA1E       = ra1_q;
    assign bus.RA2E       = ra2_q;
    assign bus.WA3E       = wa3_q;
    assign bus.ValidE     = valid_q;
    assign bus.BusyE      = busy;

`ifdef DE_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, busy_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
            busy_cnt_q   <= '0;
        end else begin
            if (bus.FlushE)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (busy && !bus.StallE)
                busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign BubbleCntE = bubble_cnt_q;
    assign BusyCntE   = busy_cnt_q;
`endif
endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg (MULT_LAT=3); define DE_PERF_CNT_EN to
// also exercise the performance counters.
module tb_decode_execute_reg;
    import de_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    decode_execute_reg_if #(.DATA_W(32), .REG_AW(4), .ALUC_W(3)) bus ();

`ifdef DE_PERF_CNT_EN
    logic [31:0] BubbleCntE, BusyCntE;
`endif

    decode_execute_reg #(.DATA_W(32), .REG_AW(4), .ALUC_W(3), .MULT_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DE_PERF_CNT_EN
        ,
        .BubbleCntE (BubbleCntE),
        .BusyCntE   (BusyCntE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        bus.StallE = 0; bus.FlushE = 0; bus.ValidD = 0; bus.MultiCycleD = 0;
        bus.PCSrcD = 0; bus.RegWriteD = 0; bus.MemWriteD = 0; bus.MemtoRegD = 0;
        bus.BranchD = 0; bus.ALUSrcD = 0; bus.NoWriteD = 0; bus.FlagWriteD = 2'b00;
        bus.CondD = 4'h0; bus.ALUControlD = 3'd0; bus.RD1D = '0; bus.RD2D = '0;
        bus.ExtImmD = '0; bus.RA1D = '0; bus.RA2D = '0; bus.WA3D = '0;
    endtask

    task automatic set_busy_d(input logic [3:0] wa3);
        bus.ValidD = 1; bus.MultiCycleD = 1; bus.RegWriteD = 1; bus.MemtoRegD = 1;
        bus.FlagWriteD = 2'b11; bus.CondD = 4'hE; bus.ALUControlD = 3'd5;
        bus.RD1D = 32'h1234_5678; bus.RD2D = 32'h0000_0042; bus.WA3D = wa3;
    endtask

    function automatic logic [63:0] all_outs();
        logic [63:0] v;
        v = '0;
        v = v | 64'({bus.PCSrcE, bus.RegWriteE, bus.MemWriteE, bus.MemtoRegE, bus.BranchE,
                     bus.ALUSrcE, bus.NoWriteE, bus.FlagWriteE, bus.CondE, bus.ALUControlE,
                     bus.RA1E, bus.RA2E, bus.WA3E, bus.ValidE, bus.BusyE});
        v = v | 64'(bus.RD1E) | 64'(bus.RD2E) | 64'(bus.ExtImmE);
        return v;
    endfunction

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 0;
        clear_d();
        bus.ValidD = 1; bus.RegWriteD = 1; bus.WA3D = 4'd6; bus.RD1D = 32'hFFFF_FFFF;
        step();
        step();
        check("reset_all_zero", all_outs(), 64'd0);
        reset = 1;
        clear_d();
        step();

        // Single-cycle op
        bus.ValidD = 1; bus.RegWriteD = 1; bus.RD1D = 32'h0000_00A5; bus.WA3D = 4'd3;
        step();
        check("sc_regwrite", 64'(bus.RegWriteE), 64'd1);
        check("sc_rd1", 64'(bus.RD1E), 64'hA5);
        check("sc_wa3", 64'(bus.WA3E), 64'd3);
        check("sc_valid", 64'(bus.ValidE), 64'd1);
        check("sc_busy", 64'(bus.BusyE), 64'd0);

        // Invalid slot: write controls masked, raw fields pass through
        bus.ValidD = 0; bus.MemtoRegD = 1; bus.MemWriteD = 1;
        step();
        check("inv_regwrite", 64'(bus.RegWriteE), 64'd0);
        check("inv_memwrite", 64'(bus.MemWriteE), 64'd0);
        check("inv_memtoreg", 64'(bus.MemtoRegE), 64'd1);
        clear_d();

        // Multi-cycle op, MULT_LAT=3
        set_busy_d(4'd5);
        step();
        check("mc1_busy", 64'(bus.BusyE), 64'd1);
        check("mc1_regwrite", 64'(bus.RegWriteE), 64'd0);
        check("mc1_flagwrite", 64'(bus.FlagWriteE), 64'd0);
        check("mc1_wa3", 64'(bus.WA3E), 64'd5);
        clear_d();
        bus.ValidD = 1; bus.RegWriteD = 1; bus.WA3D = 4'd7;
        step();
        check("mc2_busy", 64'(bus.BusyE), 64'd1);
        check("mc2_regwrite", 64'(bus.RegWriteE), 64'd0);
        check("mc2_wa3", 64'(bus.WA3E), 64'd5);
        step();
        check("mc3_busy", 64'(bus.BusyE), 64'd0);
        check("mc3_regwrite", 64'(bus.RegWriteE), 64'd1);
        check("mc3_flagwrite", 64'(bus.FlagWriteE), 64'd3);
        check("mc3_wa3", 64'(bus.WA3E), 64'd5);
        step();
        check("mc4_next_wa3", 64'(bus.WA3E), 64'd7);
        check("mc4_next_busy", 64'(bus.BusyE), 64'd0);

        // Stall during cnt==1 stretches occupancy to 5 cycles
        set_busy_d(4'd9);
        step();
        clear_d();
        bus.ValidD = 1; bus.RegWriteD = 1; bus.WA3D = 4'd2;
        step();
        check("st2_busy", 64'(bus.BusyE), 64'd1);
        bus.StallE = 1;
        step();
        check("st3_busy", 64'(bus.BusyE), 64'd1);
        check("st3_wa3", 64'(bus.WA3E), 64'd9);
        step();
        check("st4_busy", 64'(bus.BusyE), 64'd1);
        check("st4_regwrite", 64'(bus.RegWriteE), 64'd0);
        check("st4_rd1", 64'(bus.RD1E), 64'h1234_5678);
        bus.StallE = 0;
        step();
        check("st5_busy", 64'(bus.BusyE), 64'd0);
        check("st5_regwrite", 64'(bus.RegWriteE), 64'd1);
        check("st5_wa3", 64'(bus.WA3E), 64'd9);
        step();
        check("st6_next_wa3", 64'(bus.WA3E), 64'd2);

        // Flush with stall during HOLD aborts the op
        set_busy_d(4'd11);
        step();
        check("fl1_busy", 64'(bus.BusyE), 64'd1);
        bus.FlushE = 1; bus.StallE = 1;
        step();
        check("fl_all_zero", all_outs(), 64'd0);
        clear_d();
        step();
        check("fl_stays_idle", 64'(bus.BusyE), 64'd0);

        // Asynchronous reset mid-HOLD with live decode inputs
        set_busy_d(4'd12);
        step();
        check("ar_pre_busy", 64'(bus.BusyE), 64'd1);
        #2 reset = 0;
        #1;
        check("ar_async_zero", all_outs(), 64'd0);
        clear_d();
        bus.ValidD = 1; bus.RegWriteD = 1; bus.WA3D = 4'd4; bus.ExtImmD = 32'hDEAD_0001;
        reset = 1;
        #1;
        check("ar_release_zero", all_outs(), 64'd0);
        step();
        check("ar_first_wa3", 64'(bus.WA3E), 64'd4);
        check("ar_first_imm", 64'(bus.ExtImmE), 64'hDEAD_0001);
        check("ar_first_regwrite", 64'(bus.RegWriteE), 64'd1);

`ifdef DE_PERF_CNT_EN
        #2 reset = 0;
        #1 reset = 1;
        clear_d();
        check("pc_reset_bubble", 64'(BubbleCntE), 64'd0);
        bus.FlushE = 1;
        step();
        step();
        step();
        bus.FlushE = 0;
        set_busy_d(4'd1);
        step();
        clear_d();
        step();
        step();
        step();
        check("pc_bubble", 64'(BubbleCntE), 64'd3);
        check("pc_busy", 64'(BusyCntE), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
